// File: rtl/byte_ram_mfc.sv
// byte_ram_mfc: byte-addressable big-endian RAM; a request in IDLE yields MOC WAIT_CYCLES+1 cycles later (dword: second MOC WAIT_CYCLES+1 after).
// No backpressure: Enable is sampled only in IDLE, Busy is high while an access is in flight.
// Optional alignment checking is enabled by defining RAM_ALIGN_CHECK_EN; otherwise Error is tied low.
module byte_ram_mfc #(
    parameter int ADDR_W      = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              Enable,
    input  logic              ReadWrite,
    input  logic [ADDR_W-1:0] Address,
    input  logic [1:0]        Mode,
    input  logic [31:0]       DataIn,
    output logic [31:0]       DataOut,
    output logic              MOC,
    output logic              Busy,
    output logic              Error
);
    localparam int         DEPTH     = 1 << ADDR_W;
    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);
    localparam logic [1:0] MODE_B    = 2'b00;
    localparam logic [1:0] MODE_H    = 2'b01;
    localparam logic [1:0] MODE_W    = 2'b10;
    localparam logic [1:0] MODE_D    = 2'b11;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WAIT1 = 3'd1,
        DONE1 = 3'd2,
        WAIT2 = 3'd3,
        DONE2 = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [1:0]        mode_q, mode_d;
    logic              rw_q, rw_d;
    logic [31:0]       wdat_q, wdat_d;
    logic [31:0]       dout_q, dout_d;
    logic              mis_q, mis_d;

    logic [7:0]        mem [DEPTH];

    logic              misalign_chk;
    logic              in_wait;
    logic              beat_end;
    logic              beat2;
    logic              do_write;
    logic              do_read;
    logic [ADDR_W-1:0] base;
    logic [ADDR_W-1:0] lane_addr [4];
    logic [31:0]       wbeat;
    logic [3:0]        wr_be;
    logic [7:0]        wr_byte [4];
    logic [7:0]        rd_byte [4];
    logic [31:0]       rdata;

    always_comb begin : align_check
        misalign_chk = 1'b0;
`ifdef RAM_ALIGN_CHECK_EN
        unique case (Mode)
            MODE_H:  misalign_chk = Address[0];
            MODE_W:  misalign_chk = |Address[1:0];
            MODE_D:  misalign_chk = |Address[2:0];
            default: misalign_chk = 1'b0;
        endcase
`endif
    end

    // A beat commits on the edge where the wait counter goes from 1 to 0.
    always_comb begin : beat_ctrl
        in_wait  = (state_q == WAIT1) || (state_q == WAIT2);
        beat_end = in_wait && (cnt_q <= 4'd1);
        beat2    = (state_q == WAIT2);
        do_write = beat_end && !rw_q && !mis_q;
        do_read  = beat_end &&  rw_q && !mis_q;
    end

    always_comb begin : lane_map
        base = beat2 ? (addr_q + ADDR_W'(4)) : addr_q;
        for (int k = 0; k < 4; k++) begin
            lane_addr[k] = base + ADDR_W'(k);
            rd_byte[k]   = mem[lane_addr[k]];
        end
    end

    // Beat 2 of a dword write takes DataIn live at its commit edge.
    always_comb begin : write_lanes
        wbeat = beat2 ? DataIn : wdat_q;
        wr_be = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            wr_byte[k] = 8'h00;
        end
        unique case (mode_q)
            MODE_B: begin
                wr_be      = 4'b0001;
                wr_byte[0] = wbeat[7:0];
            end
            MODE_H: begin
                wr_be      = 4'b0011;
                wr_byte[0] = wbeat[15:8];
                wr_byte[1] = wbeat[7:0];
            end
            default: begin
                wr_be      = 4'b1111;
                wr_byte[0] = wbeat[31:24];
                wr_byte[1] = wbeat[23:16];
                wr_byte[2] = wbeat[15:8];
                wr_byte[3] = wbeat[7:0];
            end
        endcase
    end

    always_comb begin : read_lanes
        rdata = 32'h0;
        unique case (mode_q)
            MODE_B:  rdata = {24'h0, rd_byte[0]};
            MODE_H:  rdata = {16'h0, rd_byte[0], rd_byte[1]};
            default: rdata = {rd_byte[0], rd_byte[1], rd_byte[2], rd_byte[3]};
        endcase
    end

    always_comb begin : fsm_next
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        mode_d  = mode_q;
        rw_d    = rw_q;
        wdat_d  = wdat_q;
        mis_d   = mis_q;
        dout_d  = dout_q;
        unique case (state_q)
            IDLE: begin
                if (Enable) begin
                    addr_d  = Address;
                    mode_d  = Mode;
                    rw_d    = ReadWrite;
                    wdat_d  = DataIn;
                    mis_d   = misalign_chk;
                    cnt_d   = WAIT_LOAD;
                    state_d = WAIT1;
                end
            end
            WAIT1: begin
                cnt_d = cnt_q - 4'd1;
                if (beat_end) begin
                    state_d = DONE1;
                end
            end
            DONE1: begin
                // A faulted dword stops after its first (error) beat.
                if ((mode_q == MODE_D) && !mis_q) begin
                    cnt_d   = WAIT_LOAD;
                    state_d = WAIT2;
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT2: begin
                cnt_d = cnt_q - 4'd1;
                if (beat_end) begin
                    state_d = DONE2;
                end
            end
            DONE2: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (do_read) begin
            dout_d = rdata;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin : fsm_regs
        if (!Reset_n) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= '0;
            mode_q  <= MODE_B;
            rw_q    <= 1'b0;
            wdat_q  <= 32'h0;
            dout_q  <= 32'h0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            mode_q  <= mode_d;
            rw_q    <= rw_d;
            wdat_q  <= wdat_d;
            dout_q  <= dout_d;
            mis_q   <= mis_d;
        end
    end

    // Storage is deliberately not reset; contents survive an aborted access.
    always_ff @(posedge Clk) begin : mem_write
        if (do_write) begin
            for (int k = 0; k < 4; k++) begin
                if (wr_be[k]) begin
                    mem[lane_addr[k]] <= wr_byte[k];
                end
            end
        end
    end

    assign DataOut = dout_q;
    assign MOC     = (state_q == DONE1) || (state_q == DONE2);
    assign Busy    = (state_q != IDLE);
`ifdef RAM_ALIGN_CHECK_EN
    assign Error   = MOC && mis_q;
`else
    assign Error   = 1'b0;
`endif

endmodule

// File: tb/tb_byte_ram_mfc.sv
// Bench for byte_ram_mfc: random and directed accesses checked against a byte-array reference model.
module tb_byte_ram_mfc;
    localparam int W   = 2;
    localparam int TMO = 64;

    logic        Clk       = 1'b0;
    logic        Reset_n   = 1'b0;
    logic        Enable    = 1'b0;
    logic        ReadWrite = 1'b0;
    logic [7:0]  Address   = 8'h00;
    logic [1:0]  Mode      = 2'b00;
    logic [31:0] DataIn    = 32'h0;
    logic [31:0] DataOut;
    logic        MOC;
    logic        Busy;
    logic        Error;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0]  mem_m [256];
    logic [31:0] last_rd = 32'h0;

    typedef struct packed {
        int          c1;
        int          c2;
        logic [31:0] d1;
        logic [31:0] d2;
        logic        err;
        bit          bad;
    } obs_t;

    typedef struct packed {
        logic [31:0] d1;
        logic [31:0] d2;
        logic        err;
        int          beats;
    } exp_t;

    byte_ram_mfc #(.ADDR_W(8), .WAIT_CYCLES(W)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .Enable(Enable), .ReadWrite(ReadWrite),
        .Address(Address), .Mode(Mode), .DataIn(DataIn), .DataOut(DataOut),
        .MOC(MOC), .Busy(Busy), .Error(Error)
    );

    always #5 Clk = ~Clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Reference: an access touches size bytes from A (mod 256), big-endian; misaligned = A mod size != 0.
    task automatic model_access(input bit rw, input logic [7:0] a, input logic [1:0] m,
                                input logic [31:0] din1, input logic [31:0] din2, output exp_t e);
        int          n;
        bit          mis;
        logic [63:0] v;
        logic [63:0] sh;
        n   = (m == 2'd3) ? 8 : (1 << m);
        mis = 1'b0;
`ifdef RAM_ALIGN_CHECK_EN
        mis = (int'(a) % n) != 0;
`endif
        e.err   = mis;
        e.beats = (m == 2'd3 && !mis) ? 2 : 1;
        e.d1    = last_rd;
        e.d2    = last_rd;
        if (!mis) begin
            if (!rw) begin
                v = (m == 2'd3) ? {din1, din2} : {32'h0, din1};
                for (int k = 0; k < n; k++) begin
                    sh = v >> (8 * (n - 1 - k));
                    mem_m[8'(int'(a) + k)] = sh[7:0];
                end
            end else begin
                v = 64'h0;
                for (int k = 0; k < n; k++) begin
                    v = (v << 8) | {56'h0, mem_m[8'(int'(a) + k)]};
                end
                if (m == 2'd3) begin
                    e.d1 = v[63:32];
                    e.d2 = v[31:0];
                end else begin
                    e.d1 = v[31:0];
                    e.d2 = v[31:0];
                end
                last_rd = e.d2;
            end
        end
    endtask

    // Drives one access; observes MOC cycle indices, DataOut/Error at each MOC, and protocol violations.
    task automatic run_access(input bit rw, input logic [7:0] a, input logic [1:0] m,
                              input logic [31:0] din1, input logic [31:0] din2, input int beats,
                              output obs_t o);
        int n;
        int seen;
        int last;
        o.c1 = -1; o.c2 = -1; o.d1 = 32'h0; o.d2 = 32'h0; o.err = 1'b0; o.bad = 1'b0;
        seen = 0;
        last = -5;
        @(negedge Clk);
        Enable = 1'b1; ReadWrite = rw; Address = a; Mode = m; DataIn = din1;
        @(posedge Clk);
        n = 0;
        while (seen < beats && n < TMO) begin
            @(negedge Clk);
            n++;
            if (n == 1) Enable = 1'b0;
            if (Busy !== 1'b1) o.bad = 1'b1;
            if (MOC === 1'b1) begin
                if (last == n - 1) o.bad = 1'b1;
                last = n;
                if (seen == 0) begin
                    o.c1 = n; o.d1 = DataOut; o.err = Error;
                    DataIn = din2;
                end else begin
                    o.c2 = n - o.c1; o.d2 = DataOut;
                end
                seen++;
            end
        end
        repeat (W + 3) begin
            @(negedge Clk);
            if (MOC !== 1'b0 || Busy !== 1'b0) o.bad = 1'b1;
        end
    endtask

    task automatic xact(input bit rw, input logic [7:0] a, input logic [1:0] m,
                        input logic [31:0] din1, input logic [31:0] din2, output obs_t o, output exp_t e);
        model_access(rw, a, m, din1, din2, e);
        run_access(rw, a, m, din1, din2, e.beats, o);
    endtask

    task automatic test_reset();
        Reset_n = 1'b0;
        repeat (2) @(negedge Clk);
        n_cmp++; if (DataOut !== 32'h0) begin n_bad++; $display("FAIL rst_dataout got %h exp 0", DataOut); end
        n_cmp++; if (MOC !== 1'b0) begin n_bad++; $display("FAIL rst_moc got %b exp 0", MOC); end
        n_cmp++; if (Busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy got %b exp 0", Busy); end
        n_cmp++; if (Error !== 1'b0) begin n_bad++; $display("FAIL rst_error got %b exp 0", Error); end
        Reset_n = 1'b1;
    endtask

    task automatic test_fill();
        obs_t o; exp_t e; bit any_bad; int bad_c1;
        any_bad = 1'b0;
        bad_c1  = 0;
        for (int a = 0; a < 256; a += 4) begin
            xact(1'b0, 8'(a), 2'd2, $urandom, 32'h0, o, e);
            if (o.bad) any_bad = 1'b1;
            if (o.c1 != W + 1) bad_c1++;
        end
        n_cmp++; if (any_bad !== 1'b0) begin n_bad++; $display("FAIL fill_protocol got %b exp 0", any_bad); end
        n_cmp++; if (bad_c1 !== 0) begin n_bad++; $display("FAIL fill_moc_latency got %0d late exp 0", bad_c1); end
    endtask

    task automatic test_word_rw();
        obs_t o; exp_t e;
        xact(1'b0, 8'h10, 2'd2, 32'hDEADBEEF, 32'h0, o, e);
        n_cmp++; if (o.c1 !== W + 1) begin n_bad++; $display("FAIL word_wr_moc got %0d exp %0d", o.c1, W + 1); end
        n_cmp++; if (o.bad !== 1'b0) begin n_bad++; $display("FAIL word_wr_protocol got %b exp 0", o.bad); end
        xact(1'b1, 8'h10, 2'd2, 32'h0, 32'h0, o, e);
        n_cmp++; if (o.d1 !== 32'hDEADBEEF) begin n_bad++; $display("FAIL word_rd got %h exp deadbeef", o.d1); end
        n_cmp++; if (o.c1 !== W + 1) begin n_bad++; $display("FAIL word_rd_moc got %0d exp %0d", o.c1, W + 1); end
        xact(1'b1, 8'h11, 2'd0, 32'h0, 32'h0, o, e);
        n_cmp++; if (o.d1 !== 32'h000000AD) begin n_bad++; $display("FAIL byte_rd got %h exp 000000ad", o.d1); end
    endtask

    task automatic test_half_byte();
        obs_t o; exp_t e; logic [31:0] ex;
        xact(1'b0, 8'h20, 2'd1, 32'hFFFF1234, 32'h0, o, e);
        xact(1'b0, 8'h22, 2'd0, 32'hFFFFFF56, 32'h0, o, e);
        ex = {24'h123456, mem_m[8'h23]};
        xact(1'b1, 8'h20, 2'd2, 32'h0, 32'h0, o, e);
        n_cmp++; if (o.d1 !== ex) begin n_bad++; $display("FAIL half_byte_rd got %h exp %h", o.d1, ex); end
    endtask

    task automatic test_dword();
        obs_t o; exp_t e;
        xact(1'b0, 8'h40, 2'd3, 32'h01020304, 32'h05060708, o, e);
        n_cmp++; if (o.c1 !== W + 1) begin n_bad++; $display("FAIL dw_wr_moc1 got %0d exp %0d", o.c1, W + 1); end
        n_cmp++; if (o.c2 !== W + 1) begin n_bad++; $display("FAIL dw_wr_moc_gap got %0d exp %0d", o.c2, W + 1); end
        n_cmp++; if (o.bad !== 1'b0) begin n_bad++; $display("FAIL dw_wr_protocol got %b exp 0", o.bad); end
        xact(1'b1, 8'h40, 2'd3, 32'h0, 32'h0, o, e);
        n_cmp++; if (o.d1 !== 32'h01020304) begin n_bad++; $display("FAIL dw_rd_beat1 got %h exp 01020304", o.d1); end
        n_cmp++; if (o.d2 !== 32'h05060708) begin n_bad++; $display("FAIL dw_rd_beat2 got %h exp 05060708", o.d2); end
    endtask

    task automatic test_wrap();
        obs_t o; exp_t e; logic [7:0] wexp [4]; logic [31:0] exp_b;
        wexp = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        xact(1'b0, 8'hFE, 2'd2, 32'hAABBCCDD, 32'h0, o, e);
        for (int i = 0; i < 4; i++) begin
            xact(1'b1, 8'(8'hFE + i), 2'd0, 32'h0, 32'h0, o, e);
`ifdef RAM_ALIGN_CHECK_EN
            exp_b = e.d1;
`else
            exp_b = {24'h0, wexp[i]};
`endif
            n_cmp++; if (o.d1 !== exp_b) begin n_bad++; $display("FAIL wrap_byte%0d got %h exp %h", i, o.d1, exp_b); end
        end
    endtask

    task automatic test_reset_mid();
        obs_t o; exp_t e;
        xact(1'b1, 8'h10, 2'd2, 32'h0, 32'h0, o, e);
        @(negedge Clk);
        Enable = 1'b1; ReadWrite = 1'b0; Address = 8'h10; Mode = 2'd2; DataIn = 32'h11111111;
        @(posedge Clk);
        @(negedge Clk);
        Enable = 1'b0;
        Reset_n = 1'b0;
        #1;
        n_cmp++; if (DataOut !== 32'h0) begin n_bad++; $display("FAIL midrst_dataout got %h exp 0", DataOut); end
        n_cmp++; if (Busy !== 1'b0) begin n_bad++; $display("FAIL midrst_busy got %b exp 0", Busy); end
        n_cmp++; if (MOC !== 1'b0) begin n_bad++; $display("FAIL midrst_moc got %b exp 0", MOC); end
        @(posedge Clk);
        @(negedge Clk);
        Reset_n = 1'b1;
        last_rd = 32'h0;
        xact(1'b1, 8'h10, 2'd2, 32'h0, 32'h0, o, e);
        n_cmp++; if (o.d1 !== 32'hDEADBEEF) begin n_bad++; $display("FAIL midrst_mem got %h exp deadbeef", o.d1); end
        n_cmp++; if (o.c1 !== W + 1) begin n_bad++; $display("FAIL midrst_moc_after got %0d exp %0d", o.c1, W + 1); end
    endtask

    task automatic test_align();
        obs_t o; exp_t e;
`ifdef RAM_ALIGN_CHECK_EN
        xact(1'b0, 8'h41, 2'd2, 32'hCAFEF00D, 32'h0, o, e);
        n_cmp++; if (o.err !== 1'b1) begin n_bad++; $display("FAIL align_err got %b exp 1", o.err); end
        n_cmp++; if (o.bad !== 1'b0) begin n_bad++; $display("FAIL align_single_moc got %b exp 0", o.bad); end
        for (int i = 0; i < 4; i++) begin
            xact(1'b1, 8'(8'h41 + i), 2'd0, 32'h0, 32'h0, o, e);
            n_cmp++; if (o.d1 !== e.d1) begin n_bad++; $display("FAIL align_mem%0d got %h exp %h", i, o.d1, e.d1); end
        end
        xact(1'b1, 8'h42, 2'd2, 32'h0, 32'h0, o, e);
        n_cmp++; if (o.d1 !== e.d1) begin n_bad++; $display("FAIL align_dataout got %h exp %h", o.d1, e.d1); end
        xact(1'b0, 8'h44, 2'd3, 32'h0, 32'h0, o, e);
        n_cmp++; if (o.err !== 1'b1) begin n_bad++; $display("FAIL align_dw_err got %b exp 1", o.err); end
        n_cmp++; if (o.bad !== 1'b0) begin n_bad++; $display("FAIL align_dw_single got %b exp 0", o.bad); end
`else
        xact(1'b0, 8'h41, 2'd2, 32'hCAFEF00D, 32'h0, o, e);
        n_cmp++; if (o.err !== 1'b0) begin n_bad++; $display("FAIL unaligned_err got %b exp 0", o.err); end
        xact(1'b1, 8'h41, 2'd2, 32'h0, 32'h0, o, e);
        n_cmp++; if (o.d1 !== 32'hCAFEF00D) begin n_bad++; $display("FAIL unaligned_rd got %h exp cafef00d", o.d1); end
`endif
    endtask

    task automatic test_back_to_back();
        exp_t ew; exp_t er; int n; int mocs; int c2; logic [31:0] d; logic busy_gap;
        model_access(1'b0, 8'h80, 2'd2, 32'h5A5AC3C3, 32'h0, ew);
        model_access(1'b1, 8'h80, 2'd2, 32'h0, 32'h0, er);
        c2 = -1; d = 32'h0; busy_gap = 1'b1; mocs = 0; n = 0;
        @(negedge Clk);
        Enable = 1'b1; ReadWrite = 1'b0; Address = 8'h80; Mode = 2'd2; DataIn = 32'h5A5AC3C3;
        @(posedge Clk);
        while (mocs < 2 && n < TMO) begin
            @(negedge Clk);
            n++;
            if (n == W + 2) busy_gap = Busy;
            if (MOC === 1'b1) begin
                mocs++;
                if (mocs == 1) begin
                    ReadWrite = 1'b1;
                end else begin
                    c2 = n; d = DataOut; Enable = 1'b0;
                end
            end
        end
        Enable = 1'b0;
        n_cmp++; if (c2 !== 2 * W + 3) begin n_bad++; $display("FAIL b2b_moc2 got %0d exp %0d", c2, 2 * W + 3); end
        n_cmp++; if (d !== er.d1) begin n_bad++; $display("FAIL b2b_data got %h exp %h", d, er.d1); end
        n_cmp++; if (busy_gap !== 1'b0) begin n_bad++; $display("FAIL b2b_idle_busy got %b exp 0", busy_gap); end
        repeat (2) @(negedge Clk);
        n_cmp++; if (Busy !== 1'b0) begin n_bad++; $display("FAIL b2b_stop got %b exp 0", Busy); end
    endtask

    task automatic test_random();
        obs_t o; exp_t e; bit rw; logic [1:0] m; logic [7:0] a;
        for (int i = 0; i < 40; i++) begin
            rw = 1'($urandom_range(0, 1));
            m  = 2'($urandom_range(0, 3));
            a  = 8'($urandom);
            xact(rw, a, m, $urandom, $urandom, o, e);
            n_cmp++; if (o.c1 !== W + 1) begin n_bad++; $display("FAIL rnd%0d_moc1 got %0d exp %0d", i, o.c1, W + 1); end
            if (e.beats == 2) begin
                n_cmp++; if (o.c2 !== W + 1) begin n_bad++; $display("FAIL rnd%0d_moc2 got %0d exp %0d", i, o.c2, W + 1); end
                n_cmp++; if (o.d2 !== e.d2) begin n_bad++; $display("FAIL rnd%0d_d2 got %h exp %h", i, o.d2, e.d2); end
            end
            n_cmp++; if (o.d1 !== e.d1) begin n_bad++; $display("FAIL rnd%0d_d1 got %h exp %h", i, o.d1, e.d1); end
            n_cmp++; if (o.err !== e.err) begin n_bad++; $display("FAIL rnd%0d_err got %b exp %b", i, o.err, e.err); end
            n_cmp++; if (o.bad !== 1'b0) begin n_bad++; $display("FAIL rnd%0d_protocol got %b exp 0", i, o.bad); end
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_word_rw();
        test_half_byte();
        test_dword();
        test_wrap();
        test_reset_mid();
        test_align();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/byte_ram_mfc.md
# byte_ram_mfc

Parametrised, synchronous, byte-addressable big-endian RAM with a memory-operation-complete (MOC) handshake and configurable wait states. It is the data/instruction memory behind the CPU's memory-access control unit. It supports byte, halfword, word and two-beat doubleword transfers. Address arithmetic is modulo the memory depth.

## Interface
- ADDR_W, 8, byte-address width; depth = 2^ADDR_W bytes.
- WAIT_CYCLES, 2, wait-state cycles per beat; legal range 1..15.
- Clk  in  1  rising-edge clock.
- Reset_n  in  1  asynchronous, active-low reset.
- Enable  in  1  request; sampled only in IDLE.
- ReadWrite  in  1  1 = read, 0 = write.
- Address  in  ADDR_W  start byte address.
- Mode  in  2  00 byte, 01 halfword, 10 word, 11 doubleword (two 32-bit beats).
- DataIn  in  32  write data, right-justified for byte/halfword.
- DataOut  out  32  read data, zero-extended and right-justified.
- MOC  out  1  one-cycle pulse per completed beat.
- Busy  out  1  high while an access is in progress.
- Error  out  1  alignment fault, valid with MOC.

## Operation
- FSM states: IDLE, WAIT1, DONE1, WAIT2, DONE2.
- IDLE with Enable=1: at that edge, capture Address, Mode, ReadWrite and DataIn, load the wait counter with WAIT_CYCLES, then go to WAIT1. Enable in any other state is ignored.
- WAIT1/WAIT2: the counter decrements each cycle. On the edge where it reaches 0, the beat commits and the FSM moves to DONE1/DONE2.
- Write commit: all bytes of the beat are written on the same edge.
  - Byte: Mem[A] = DataIn[7:0].
  - Halfword: Mem[A] = [15:8], Mem[A+1] = [7:0].
  - Word/dword beat: Mem[A..A+3] = [31:24]..[7:0].
- Read commit: DataOut is loaded with big-endian data, upper bits zeroed for byte/halfword. DataOut holds until the next read commit; writes never change it.
- DONE1: MOC=1.
  - Mode 11: reload the counter and go to WAIT2.
  - Otherwise: go to IDLE.
- Dword beat 2 uses bytes A+4..A+7.
  - Write data is sampled from DataIn at the beat-2 commit edge.
  - Read DataOut = {Mem[A+4]..Mem[A+7]}.
- DONE2: MOC=1, then go to IDLE.
- Address wrap: A+k is computed modulo 2^ADDR_W; e.g. a word at 0xFE touches 0xFE, 0xFF, 0x00, 0x01.
- Memory contents are not reset and power up as X.

## Timing
- Reset: state=IDLE, DataOut=0, MOC=0, Busy=0, Error=0, counter=0.
- Reset asserted mid-access aborts immediately. Beats already committed stay in memory; an uncommitted beat writes nothing.
- Accept on edge t0. Busy=1 from t0 through the last DONE cycle.
- First MOC is high in cycle t0+WAIT_CYCLES+1 (1-based cycle count after the t0 edge).
- Dword second MOC comes WAIT_CYCLES+1 cycles after the first.
- Requester rule: drop Enable on seeing the final MOC. If Enable is still high in IDLE, a new access starts.
- Dword write: the requester updates DataIn after seeing the first MOC. Because WAIT_CYCLES ≥ 1, the new value is present at the beat-2 commit edge.
- MOC is never high in two consecutive cycles.

## Configuration
- RAM_ALIGN_CHECK_EN defined: an access is misaligned if it is
  - a halfword at an odd address,
  - a word with A[1:0]≠0, or
  - a doubleword with A[2:0]≠0.
- Misaligned access behaviour: the full wait timing runs, but no memory write and no DataOut update occur.
  - A single MOC is issued with Error=1; a dword does not run its second beat.
  - The FSM then returns to IDLE.
- Macro undefined: no alignment check, Error is tied 0, and unaligned accesses proceed with wrap-around.

## Test plan
- Reset: Reset_n low mid-WAIT1 → DataOut=0, MOC=0, Busy=0 immediately; next access behaves normally.
- Word write then read: write 0xDEADBEEF at 0x10, then read word 0x10 → DataOut=0xDEADBEEF. Byte read 0x11 → 0x000000AD. MOC in cycle WAIT_CYCLES+1.
- Halfword/byte write: halfword 0x1234 at 0x20 and byte 0x56 at 0x22, then word read 0x20 → 0x123456xx (xx = prior contents).
- Doubleword write: words 0x01020304 then 0x05060708 at 0x40, two MOCs spaced WAIT_CYCLES+1 cycles apart. Dword read → 0x01020304, then 0x05060708.
- Wrap: word write 0xAABBCCDD at 0xFE (ADDR_W=8) → bytes 0xFE=AA, 0xFF=BB, 0x00=CC, 0x01=DD.
- With RAM_ALIGN_CHECK_EN: word write at 0x41 → single MOC with Error=1; memory at 0x41..0x44 unchanged; DataOut unchanged.
